// File: rtl/ika87ad_pkg.sv
// ika87ad interrupt arbiter shared definitions.
// Source codes, group vectors and FSM/ack-mode enums.
package ika87ad_pkg;

  localparam logic [4:0] IRQ_NMI  = 5'd0;
  localparam logic [4:0] IRQ_T0   = 5'd1;
  localparam logic [4:0] IRQ_T1   = 5'd2;
  localparam logic [4:0] IRQ_INT1 = 5'd3;
  localparam logic [4:0] IRQ_INT2 = 5'd4;
  localparam logic [4:0] IRQ_E0   = 5'd5;
  localparam logic [4:0] IRQ_E1   = 5'd6;
  localparam logic [4:0] IRQ_EIN  = 5'd7;
  localparam logic [4:0] IRQ_AD   = 5'd8;
  localparam logic [4:0] IRQ_SR   = 5'd9;
  localparam logic [4:0] IRQ_ST   = 5'd10;

  localparam logic [15:0] VEC_NMI = 16'h0004;
  localparam logic [15:0] VEC_TMR = 16'h0008;
  localparam logic [15:0] VEC_INT = 16'h0010;
  localparam logic [15:0] VEC_CNT = 16'h0018;
  localparam logic [15:0] VEC_EAD = 16'h0020;
  localparam logic [15:0] VEC_SER = 16'h0028;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_WAIT
  } irq_state_e;

  typedef enum logic [1:0] {
    MODE_AUTO,
    MODE_MANUAL,
    MODE_SOFT
  } ack_mode_e;

endpackage

// File: rtl/ika87ad_irq_prienc.sv
// ika87ad fixed-priority interrupt encoder.
// Returns pending, source code, group vector and group multi flag.
module ika87ad_irq_prienc
  import ika87ad_pkg::*;
(
  input  logic [10:0] flag_i,
  input  logic [10:0] mask_i,
  input  logic        ie_i,
  output logic        pend_o,
  output logic [4:0]  code_o,
  output logic [15:0] vec_o,
  output logic        multi_o
);

  logic [10:0] act;
  logic [4:0]  grp_m;
  logic        unused_mask0;

  assign act = {flag_i[10:1] & ~mask_i[10:1] & {10{ie_i}},
                flag_i[0]};
  assign grp_m = {~mask_i[9] & ~mask_i[10],
                  ~mask_i[7] & ~mask_i[8],
                  ~mask_i[5] & ~mask_i[6],
                  ~mask_i[3] & ~mask_i[4],
                  ~mask_i[1] & ~mask_i[2]};
  assign unused_mask0 = mask_i[0];
  assign pend_o = |act;

  // lowest active index wins; pairs share a vector
  always_comb begin
    code_o  = IRQ_NMI;
    vec_o   = 16'h0000;
    multi_o = 1'b0;
    priority case (1'b1)
      act[0]:  begin code_o = IRQ_NMI;  vec_o = VEC_NMI; end
      act[1]:  begin code_o = IRQ_T0;   vec_o = VEC_TMR; multi_o = grp_m[0]; end
      act[2]:  begin code_o = IRQ_T1;   vec_o = VEC_TMR; multi_o = grp_m[0]; end
      act[3]:  begin code_o = IRQ_INT1; vec_o = VEC_INT; multi_o = grp_m[1]; end
      act[4]:  begin code_o = IRQ_INT2; vec_o = VEC_INT; multi_o = grp_m[1]; end
      act[5]:  begin code_o = IRQ_E0;   vec_o = VEC_CNT; multi_o = grp_m[2]; end
      act[6]:  begin code_o = IRQ_E1;   vec_o = VEC_CNT; multi_o = grp_m[2]; end
      act[7]:  begin code_o = IRQ_EIN;  vec_o = VEC_EAD; multi_o = grp_m[3]; end
      act[8]:  begin code_o = IRQ_AD;   vec_o = VEC_EAD; multi_o = grp_m[3]; end
      act[9]:  begin code_o = IRQ_SR;   vec_o = VEC_SER; multi_o = grp_m[4]; end
      act[10]: begin code_o = IRQ_ST;   vec_o = VEC_SER; multi_o = grp_m[4]; end
      default: begin code_o = IRQ_NMI;  vec_o = 16'h0000; multi_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ika87ad_irq_arbiter.sv
// ika87ad interrupt arbiter: request FSM, ack strobes, SKIT queue.
// Optional software interrupt enabled by IKA87AD_SOFTI_EN.
module ika87ad_irq_arbiter
  import ika87ad_pkg::*;
#(
  parameter logic [15:0] SOFTI_VECTOR = 16'h0060
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST,
  input  logic        i_RSTTICK,
  input  logic [10:0] i_IFLAG,
  input  logic [10:0] i_MASK,
  input  logic        i_IE,
  input  logic        i_IRQ_ACK,
  input  logic        i_SKIT,
  input  logic [4:0]  i_SKIT_CODE,
  input  logic        i_SOFTI,
  output logic        o_IRQ_REQ,
  output logic [15:0] o_IRQ_VECTOR,
  output logic [4:0]  o_ACK_CODE,
  output logic        o_AUTO_ACK,
  output logic        o_MANUAL_ACK,
  output logic        o_MULTI_IRQ_ENABLED
);

  irq_state_e  state_q, state_d;
  ack_mode_e   mode_q, mode_d;
  logic        req_q, req_d;
  logic [15:0] vec_q, vec_d;
  logic [4:0]  code_q, code_d;
  logic        rmul_q, rmul_d;
  logic        auto_q, auto_d;
  logic        man_q, man_d;
  logic        mul_q, mul_d;
  logic        skv_q, skv_d;
  logic [4:0]  skc_q, skc_d;

  logic        p_pend, p_multi;
  logic [4:0]  p_code;
  logic [15:0] p_vec;
  logic        r_pend, r_multi, r_soft;
  logic [4:0]  r_code;
  logic [15:0] r_vec;

  ika87ad_irq_prienc u_prienc (
    .flag_i  (i_IFLAG),
    .mask_i  (i_MASK),
    .ie_i    (i_IE),
    .pend_o  (p_pend),
    .code_o  (p_code),
    .vec_o   (p_vec),
    .multi_o (p_multi)
  );

`ifdef IKA87AD_SOFTI_EN
  logic soft_q, soft_d;

  assign r_soft  = i_SOFTI | soft_q;
  assign soft_d  = i_SOFTI | (soft_q & ~(state_q == ST_REQ
                   & i_IRQ_ACK & mode_q == MODE_SOFT));

  // software request stays latched until acknowledged
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) soft_q <= 1'b0;
    else        soft_q <= soft_d;
  end
`else
  logic unused_softi;

  assign r_soft       = 1'b0;
  assign unused_softi = i_SOFTI;
`endif

  assign r_pend  = r_soft | p_pend;
  assign r_code  = r_soft ? IRQ_NMI : p_code;
  assign r_vec   = r_soft ? SOFTI_VECTOR : p_vec;
  assign r_multi = r_soft ? 1'b0 : p_multi;

  // state and output registers
  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_AUTO;
      req_q   <= 1'b0;
      vec_q   <= 16'h0000;
      code_q  <= 5'd0;
      rmul_q  <= 1'b0;
      auto_q  <= 1'b0;
      man_q   <= 1'b0;
      mul_q   <= 1'b0;
      skv_q   <= 1'b0;
      skc_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      code_q  <= code_d;
      rmul_q  <= rmul_d;
      auto_q  <= auto_d;
      man_q   <= man_d;
      mul_q   <= mul_d;
      skv_q   <= skv_d;
      skc_q   <= skc_d;
    end
  end

  // next-state, request resolution, ack strobes and SKIT queue
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    req_d   = req_q;
    vec_d   = vec_q;
    code_d  = code_q;
    rmul_d  = rmul_q;
    auto_d  = auto_q;
    man_d   = man_q;
    mul_d   = mul_q;
    skv_d   = skv_q;
    skc_d   = skc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (r_pend) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          vec_d   = r_vec;
          code_d  = r_code;
          rmul_d  = r_multi;
          mode_d  = r_soft ? MODE_SOFT : MODE_AUTO;
        end else if (skv_q) begin
          state_d = ST_ACK;
          mode_d  = MODE_MANUAL;
          man_d   = 1'b1;
          code_d  = skc_q;
          skv_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_IRQ_ACK) begin
          state_d = ST_ACK;
          req_d   = 1'b0;
          if (mode_q != MODE_SOFT) begin
            auto_d = ~rmul_q;
            mul_d  = rmul_q;
          end
        end else if (skv_q) begin
          state_d = ST_ACK;
          req_d   = 1'b0;
          mode_d  = MODE_MANUAL;
          man_d   = 1'b1;
          code_d  = skc_q;
          skv_d   = 1'b0;
        end else if (!r_pend) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          code_d  = 5'd0;
        end else begin
          vec_d  = r_vec;
          code_d = r_code;
          rmul_d = r_multi;
          mode_d = r_soft ? MODE_SOFT : MODE_AUTO;
        end
      end
      ST_ACK: begin
        if (i_RSTTICK) begin
          state_d = ST_WAIT;
          auto_d  = 1'b0;
          man_d   = 1'b0;
          mul_d   = 1'b0;
          code_d  = 5'd0;
        end
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (i_SKIT) begin
      skv_d = 1'b1;
      skc_d = i_SKIT_CODE;
    end
  end

  assign o_IRQ_REQ           = req_q;
  assign o_IRQ_VECTOR        = vec_q;
  assign o_ACK_CODE          = code_q;
  assign o_AUTO_ACK          = auto_q;
  assign o_MANUAL_ACK        = man_q;
  assign o_MULTI_IRQ_ENABLED = mul_q;

endmodule

// File: tb/tb_ika87ad_irq_arbiter.sv
// Directed bench for ika87ad_irq_arbiter.
// Expected output bundles are queued per step and checked after each edge.
module tb_ika87ad_irq_arbiter;

  logic        clk = 1'b0;
  logic        mrst, rsttick, ie, ack, skit, softi;
  logic [10:0] iflag, mask;
  logic [4:0]  skcode;
  logic        req, aut, man, mul;
  logic [15:0] vec;
  logic [4:0]  code;
  logic [24:0] obs;

  int checks = 0;
  int errors = 0;

  string       tq[$];
  logic [24:0] vq[$];

  always #5 clk = ~clk;

  ika87ad_irq_arbiter dut (
    .i_EMUCLK            (clk),
    .i_MRST              (mrst),
    .i_RSTTICK           (rsttick),
    .i_IFLAG             (iflag),
    .i_MASK              (mask),
    .i_IE                (ie),
    .i_IRQ_ACK           (ack),
    .i_SKIT              (skit),
    .i_SKIT_CODE         (skcode),
    .i_SOFTI             (softi),
    .o_IRQ_REQ           (req),
    .o_IRQ_VECTOR        (vec),
    .o_ACK_CODE          (code),
    .o_AUTO_ACK          (aut),
    .o_MANUAL_ACK        (man),
    .o_MULTI_IRQ_ENABLED (mul)
  );

  assign obs = {req, vec, code, aut, man, mul};

  task automatic push(input string t, input logic r,
                      input logic [15:0] v, input logic [4:0] c,
                      input logic a, input logic m, input logic mu);
    tq.push_back(t);
    vq.push_back({r, v, c, a, m, mu});
  endtask

  task automatic cyc();
    string       t;
    logic [24:0] e;
    @(posedge clk);
    #1;
    while (vq.size() > 0) begin
      t = tq.pop_front();
      e = vq.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed req=%b vec=%h code=%0d auto=%b man=%b multi=%b expected req=%b vec=%h code=%0d auto=%b man=%b multi=%b",
               t, obs[24], obs[23:8], obs[7:3], obs[2], obs[1], obs[0],
               e[24], e[23:8], e[7:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    mrst = 1'b1; rsttick = 1'b0; ie = 1'b0; ack = 1'b0;
    skit = 1'b0; softi = 1'b0; iflag = '0; mask = '1; skcode = '0;
    push("reset", 0, 16'h0000, 0, 0, 0, 0); cyc();
    push("reset2", 0, 16'h0000, 0, 0, 0, 0); cyc();

    // NMI with IE=0 and everything masked
    mrst = 1'b0; iflag = 11'h001;
    push("nmi_req", 1, 16'h0004, 0, 0, 0, 0); cyc();
    ack = 1'b1;
    push("nmi_ack", 0, 16'h0004, 0, 1, 0, 0); cyc();
    ack = 1'b0;
    push("nmi_hold", 0, 16'h0004, 0, 1, 0, 0); cyc();
    rsttick = 1'b1; iflag = '0;
    push("nmi_tick", 0, 16'h0004, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("nmi_wait", 0, 16'h0004, 0, 0, 0, 0); cyc();

    // T1 then T0 preempts inside REQ, both unmasked
    ie = 1'b1; mask = '0; iflag = 11'h004;
    push("t1_req", 1, 16'h0008, 2, 0, 0, 0); cyc();
    iflag = 11'h006;
    push("t0_preempt", 1, 16'h0008, 1, 0, 0, 0); cyc();
    ack = 1'b1;
    push("t0_ack", 0, 16'h0008, 1, 0, 0, 1); cyc();
    ack = 1'b0; rsttick = 1'b1; iflag = '0;
    push("t0_tick", 0, 16'h0008, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("t0_wait", 0, 16'h0008, 0, 0, 0, 0); cyc();

    // INT2 request withdrawn by DI
    iflag = 11'h010;
    push("int2_req", 1, 16'h0010, 4, 0, 0, 0); cyc();
    ie = 1'b0;
    push("int2_di", 0, 16'h0010, 0, 0, 0, 0); cyc();
    push("int2_idle", 0, 16'h0010, 0, 0, 0, 0); cyc();
    iflag = '0; ie = 1'b1;

    // INT1 auto ack, SKIT code 9 queued during ACK
    mask = 11'h010; iflag = 11'h008;
    push("int1_req", 1, 16'h0010, 3, 0, 0, 0); cyc();
    ack = 1'b1;
    push("int1_ack", 0, 16'h0010, 3, 1, 0, 0); cyc();
    ack = 1'b0; skit = 1'b1; skcode = 5'd9;
    push("skit_in_ack", 0, 16'h0010, 3, 1, 0, 0); cyc();
    skit = 1'b0; rsttick = 1'b1; iflag = '0;
    push("int1_tick", 0, 16'h0010, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("skit_wait", 0, 16'h0010, 0, 0, 0, 0); cyc();
    push("man_ack", 0, 16'h0010, 9, 0, 1, 0); cyc();
    push("man_hold", 0, 16'h0010, 9, 0, 1, 0); cyc();
    rsttick = 1'b1;
    push("man_tick", 0, 16'h0010, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("man_wait", 0, 16'h0010, 0, 0, 0, 0); cyc();

    // ack outside REQ is ignored
    ack = 1'b1; mask = '0;
    push("ack_idle", 0, 16'h0010, 0, 0, 0, 0); cyc();
    ack = 1'b0;

    // ack beats a SKIT in the same cycle; SKIT served afterwards
    iflag = 11'h020;
    push("e0_req", 1, 16'h0018, 5, 0, 0, 0); cyc();
    ack = 1'b1; skit = 1'b1; skcode = 5'd12;
    push("ack_beats_skit", 0, 16'h0018, 5, 0, 0, 1); cyc();
    ack = 1'b0; skit = 1'b0; rsttick = 1'b1; iflag = '0;
    push("e0_tick", 0, 16'h0018, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("e0_wait", 0, 16'h0018, 0, 0, 0, 0); cyc();
    push("skit_after", 0, 16'h0018, 12, 0, 1, 0); cyc();
    rsttick = 1'b1;
    push("skit_tick", 0, 16'h0018, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("skit_idle", 0, 16'h0018, 0, 0, 0, 0); cyc();

    // SKIT served from REQ when no ack arrives
    iflag = 11'h080;
    push("ein_req", 1, 16'h0020, 7, 0, 0, 0); cyc();
    skit = 1'b1; skcode = 5'd8;
    push("skit_req_q", 1, 16'h0020, 7, 0, 0, 0); cyc();
    skit = 1'b0;
    push("skit_from_req", 0, 16'h0020, 8, 0, 1, 0); cyc();
    rsttick = 1'b1;
    push("sreq_tick", 0, 16'h0020, 0, 0, 0, 0); cyc();
    rsttick = 1'b0; iflag = '0;
    push("sreq_wait", 0, 16'h0020, 0, 0, 0, 0); cyc();

    // reset in ACK, then SR
    iflag = 11'h002;
    push("t0b_req", 1, 16'h0008, 1, 0, 0, 0); cyc();
    ack = 1'b1;
    push("t0b_ack", 0, 16'h0008, 1, 0, 0, 1); cyc();
    ack = 1'b0; mrst = 1'b1; iflag = '0;
    push("mrst", 0, 16'h0000, 0, 0, 0, 0); cyc();
    mrst = 1'b0; iflag = 11'h200;
    push("sr_req", 1, 16'h0028, 9, 0, 0, 0); cyc();
    ack = 1'b1;
    push("sr_ack", 0, 16'h0028, 9, 0, 0, 1); cyc();
    ack = 1'b0; rsttick = 1'b1; iflag = '0;
    push("sr_tick", 0, 16'h0028, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("sr_wait", 0, 16'h0028, 0, 0, 0, 0); cyc();

`ifdef IKA87AD_SOFTI_EN
    // software interrupt outranks NMI
    ie = 1'b0; mask = '1; iflag = 11'h001; softi = 1'b1;
    push("soft_req", 1, 16'h0060, 0, 0, 0, 0); cyc();
    softi = 1'b0; ack = 1'b1;
    push("soft_ack", 0, 16'h0060, 0, 0, 0, 0); cyc();
    ack = 1'b0; rsttick = 1'b1;
    push("soft_tick", 0, 16'h0060, 0, 0, 0, 0); cyc();
    rsttick = 1'b0;
    push("soft_wait", 0, 16'h0060, 0, 0, 0, 0); cyc();
    push("nmi_after_soft", 1, 16'h0004, 0, 0, 0, 0); cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
